// File: rtl/int_datapath_md.sv
// Integer execute datapath: register file with write-back bypass, operand pipeline,
// ALU with flags, HI/LO, Y-mux and an iterative one-bit-per-cycle multiply/divide unit.
module int_datapath_md #(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter int SP_ADDR = 29,
  parameter int RA_ADDR = 31
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       FS,
  input  logic             D_En,
  input  logic [AW-1:0]    D_Addr,
  input  logic [AW-1:0]    S_Addr,
  input  logic [AW-1:0]    T_Addr,
  input  logic [1:0]       DA_sel,
  input  logic             T_Sel,
  input  logic [WIDTH-1:0] DT,
  input  logic [WIDTH-1:0] DY,
  input  logic [WIDTH-1:0] PC_in,
  input  logic [2:0]       Y_Sel,
  input  logic             MD_start,
  input  logic [1:0]       MD_op,
  output logic             MD_busy,
  output logic             MD_done,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] D_OUT
);

  localparam int NREG = 2 ** AW;
  localparam int SW   = $clog2(WIDTH);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

  logic [WIDTH-1:0] regs [NREG];
  logic [AW-1:0]    dest;
  logic             wr_ok;
  logic [WIDTH-1:0] s_port, t_port;
  logic [WIDTH-1:0] rs_reg, rt_reg, din_reg, alu_reg, hi_reg, lo_reg;

  always_comb begin
    case (DA_sel)
      2'd0:    dest = D_Addr;
      2'd1:    dest = T_Addr;
      2'd2:    dest = AW'(RA_ADDR);
      default: dest = AW'(SP_ADDR);
    endcase
  end

  // r0 is never written, so it reads as zero without a special read path
  assign wr_ok = D_En && (dest != '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[dest] <= ALU_OUT;
    end
  end

  assign s_port = (wr_ok && dest == S_Addr) ? ALU_OUT : regs[S_Addr];
  assign t_port = (wr_ok && dest == T_Addr) ? ALU_OUT : regs[T_Addr];

  // ALU
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_y;
  logic             c_flag, v_flag;

  assign add_sum = {1'b0, rs_reg} + {1'b0, rt_reg};
  assign sub_sum = {1'b0, rs_reg} + {1'b0, ~rt_reg} + (WIDTH+1)'(1);
  assign shamt   = rs_reg[SW-1:0];

  always_comb begin
    alu_y  = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (FS)
      4'h0: alu_y = rs_reg;
      4'h1: alu_y = rt_reg;
      4'h2: begin
        alu_y  = add_sum[WIDTH-1:0];
        c_flag = add_sum[WIDTH];
        v_flag = (rs_reg[WIDTH-1] == rt_reg[WIDTH-1]) && (add_sum[WIDTH-1] != rs_reg[WIDTH-1]);
      end
      4'h3: begin
        alu_y  = add_sum[WIDTH-1:0];
        c_flag = add_sum[WIDTH];
      end
      4'h4: begin
        alu_y  = sub_sum[WIDTH-1:0];
        c_flag = sub_sum[WIDTH];
        v_flag = (rs_reg[WIDTH-1] != rt_reg[WIDTH-1]) && (sub_sum[WIDTH-1] != rs_reg[WIDTH-1]);
      end
      4'h5: begin
        alu_y  = sub_sum[WIDTH-1:0];
        c_flag = sub_sum[WIDTH];
      end
      4'h6: alu_y = WIDTH'($signed(rs_reg) < $signed(rt_reg));
      4'h7: alu_y = WIDTH'(rs_reg < rt_reg);
      4'h8: alu_y = rs_reg & rt_reg;
      4'h9: alu_y = rs_reg | rt_reg;
      4'hA: alu_y = rs_reg ^ rt_reg;
      4'hB: alu_y = ~(rs_reg | rt_reg);
      4'hC: alu_y = rt_reg << shamt;
      4'hD: alu_y = rt_reg >> shamt;
      4'hE: alu_y = WIDTH'($signed(rt_reg) >>> shamt);
      default: alu_y = rt_reg << (WIDTH / 2);
    endcase
  end

  assign C = c_flag;
  assign V = v_flag;
  assign N = alu_y[WIDTH-1];
  assign Z = (alu_y == '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rs_reg  <= '0;
      rt_reg  <= '0;
      din_reg <= '0;
      alu_reg <= '0;
    end else begin
      rs_reg  <= s_port;
      rt_reg  <= T_Sel ? DT : t_port;
      din_reg <= DY;
      alu_reg <= alu_y;
    end
  end

  // Multiply/divide: operands are held as magnitudes, signs are reapplied at the end
  md_state_t        state_reg, state_next;
  logic [SW-1:0]    cnt_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, rs_cap_reg;
  logic             neg_q_reg, neg_r_reg;
  logic             md_load, md_step, md_finish;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_step, b_step, hi_fin, lo_fin;
  logic [2*WIDTH-1:0] prod;

  assign rs_neg = MD_op[0] & rs_reg[WIDTH-1];
  assign rt_neg = MD_op[0] & rt_reg[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_reg : rs_reg;
  assign rt_mag = rt_neg ? -rt_reg : rt_reg;

  assign mul_sum   = {1'b0, acc_reg} + (b_reg[0] ? {1'b0, a_reg} : '0);
  assign div_shift = {acc_reg, b_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, a_reg};
  assign div_ge    = (div_shift >= {1'b0, a_reg});

  always_comb begin
    if (op_reg[1]) begin
      acc_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      b_step   = {b_reg[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      b_step   = {mul_sum[0], b_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = neg_q_reg ? -{acc_step, b_step} : {acc_step, b_step};
    hi_fin = prod[2*WIDTH-1:WIDTH];
    lo_fin = prod[WIDTH-1:0];
    if (op_reg[1]) begin
      if (a_reg == '0) begin
        hi_fin = rs_cap_reg;
        lo_fin = '1;
      end else begin
        hi_fin = neg_r_reg ? -acc_step : acc_step;
        lo_fin = neg_q_reg ? -b_step : b_step;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_reg <= MD_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    md_load    = 1'b0;
    md_step    = 1'b0;
    md_finish  = 1'b0;
    MD_busy    = 1'b0;
    MD_done    = 1'b0;
    case (state_reg)
      MD_RUN: begin
        MD_busy = 1'b1;
        md_step = 1'b1;
        if (cnt_reg == SW'(WIDTH - 1)) begin
          md_finish  = 1'b1;
          state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        MD_done = 1'b1;
        if (MD_start) begin
          md_load    = 1'b1;
          state_next = MD_RUN;
        end else begin
          state_next = MD_IDLE;
        end
      end
      default: begin
        if (MD_start) begin
          md_load    = 1'b1;
          state_next = MD_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      rs_cap_reg <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (md_load) begin
      cnt_reg    <= '0;
      op_reg     <= MD_op;
      a_reg      <= MD_op[1] ? rt_mag : rs_mag;
      b_reg      <= MD_op[1] ? rs_mag : rt_mag;
      acc_reg    <= '0;
      rs_cap_reg <= rs_reg;
      neg_q_reg  <= rs_neg ^ rt_neg;
      neg_r_reg  <= rs_neg;
    end else if (md_step) begin
      cnt_reg <= cnt_reg + SW'(1);
      acc_reg <= acc_step;
      b_reg   <= b_step;
      if (md_finish) begin
        hi_reg <= hi_fin;
        lo_reg <= lo_fin;
      end
    end
  end

  always_comb begin
    case (Y_Sel)
      3'd1:    ALU_OUT = PC_in;
      3'd2:    ALU_OUT = din_reg;
      3'd3:    ALU_OUT = lo_reg;
      3'd4:    ALU_OUT = hi_reg;
      default: ALU_OUT = alu_reg;
    endcase
  end

  assign D_OUT = rt_reg;

endmodule

// File: tb/tb_int_datapath_md.sv
// Directed bench for int_datapath_md (WIDTH=32): regfile/bypass, ALU flags,
// mul/div results, handshake timing and mid-operation reset.
module tb_int_datapath_md;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  FS = '0;
  logic        D_En = 1'b0;
  logic [4:0]  D_Addr = '0, S_Addr = '0, T_Addr = '0;
  logic [1:0]  DA_sel = '0;
  logic        T_Sel = 1'b0;
  logic [31:0] DT = '0, DY = '0, PC_in = '0;
  logic [2:0]  Y_Sel = '0;
  logic        MD_start = 1'b0;
  logic [1:0]  MD_op = '0;
  logic        MD_busy, MD_done, C, V, N, Z;
  logic [31:0] ALU_OUT, D_OUT;

  int n_checks = 0;
  int n_pass = 0;

  int_datapath_md #(.WIDTH(32), .AW(5), .SP_ADDR(29), .RA_ADDR(31)) dut (
    .CLK(CLK), .RESET(RESET), .FS(FS), .D_En(D_En), .D_Addr(D_Addr),
    .S_Addr(S_Addr), .T_Addr(T_Addr), .DA_sel(DA_sel), .T_Sel(T_Sel),
    .DT(DT), .DY(DY), .PC_in(PC_in), .Y_Sel(Y_Sel), .MD_start(MD_start),
    .MD_op(MD_op), .MD_busy(MD_busy), .MD_done(MD_done), .C(C), .V(V),
    .N(N), .Z(Z), .ALU_OUT(ALU_OUT), .D_OUT(D_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v, input logic [1:0] sel);
    DY = v;
    tick();
    Y_Sel = 3'd2; D_Addr = a; DA_sel = sel; D_En = 1'b1;
    tick();
    D_En = 1'b0; Y_Sel = 3'd0; DA_sel = 2'd0;
    $display("write sel=%0d addr=%0d data=0x%h", sel, a, v);
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    T_Sel = 1'b0; T_Addr = a;
    tick();
    v = D_OUT;
  endtask

  task automatic alu(input string tag, input logic [3:0] fs, input logic [4:0] sa,
                     input logic [31:0] tv, input logic [31:0] ey, input logic [3:0] ecvnz);
    FS = fs; S_Addr = sa; T_Sel = 1'b1; DT = tv; Y_Sel = 3'd0;
    tick();
    check({tag, "_cvnz"}, 32'({C, V, N, Z}), 32'(ecvnz));
    tick();
    check({tag, "_y"}, ALU_OUT, ey);
    $display("alu %s fs=%h t=0x%h y=0x%h cvnz=%b", tag, fs, tv, ALU_OUT, {C, V, N, Z});
  endtask

  task automatic md_go(input logic [1:0] op, input logic [4:0] sa, input logic [31:0] tv);
    S_Addr = sa; T_Sel = 1'b1; DT = tv;
    tick();
    MD_op = op; MD_start = 1'b1;
    tick();
    MD_start = 1'b0;
  endtask

  // Called just after the start edge; returns in the DONE cycle.
  task automatic md_wait(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic [31:0] prev_lo, input bit pulse_mid);
    int busy_cnt = 0;
    int done_at = 0;
    Y_Sel = 3'd3;
    for (int k = 0; k < 40 && done_at == 0; k++) begin
      if (MD_busy) busy_cnt++;
      if (k == 5) check({tag, "_lo_hold"}, ALU_OUT, prev_lo);
      MD_start = pulse_mid && (k == 10);
      tick();
      if (MD_done) done_at = k + 1;
    end
    MD_start = 1'b0;
    check({tag, "_latency"}, 32'(done_at), 32);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32);
    check({tag, "_busy_at_done"}, 32'(MD_busy), 0);
    check({tag, "_lo"}, ALU_OUT, exp_lo);
    Y_Sel = 3'd4;
    #1;
    check({tag, "_hi"}, ALU_OUT, exp_hi);
    $display("md %s done_after=%0d hi=0x%h", tag, done_at, ALU_OUT);
    Y_Sel = 3'd0;
  endtask

  initial begin
    logic [31:0] v;
    int done_seen;

    // Reset and preload
    repeat (2) tick();
    check("rst_alu_out", ALU_OUT, 0);
    check("rst_md_busy", 32'(MD_busy), 0);
    RESET = 1'b1;
    tick();
    write_reg(5'd3, 32'h0000_1234, 2'd0);
    write_reg(5'd31, 32'hABCD_0000, 2'd0);
    read_reg(5'd3, v);
    check("preload_r3", v, 32'h0000_1234);

    // Asynchronous reset with live state
    DY = 32'h0000_1234; Y_Sel = 3'd2;
    tick();
    #2 RESET = 1'b0;
    #1;
    check("async_rst_din", ALU_OUT, 0);
    check("async_rst_busy", 32'(MD_busy), 0);
    DY = '0; Y_Sel = 3'd0;
    #1 RESET = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_reg(i[4:0], v);
      check($sformatf("rst_r%0d", i), v, 0);
    end

    write_reg(5'd0, 32'h55, 2'd0);
    read_reg(5'd0, v);
    check("r0_write_ignored", v, 0);
    write_reg(5'd0, 32'hA1, 2'd2);
    read_reg(5'd31, v);
    check("dasel_ra", v, 32'hA1);
    write_reg(5'd0, 32'hB2, 2'd3);
    read_reg(5'd29, v);
    check("dasel_sp", v, 32'hB2);
    T_Addr = 5'd12;
    write_reg(5'd0, 32'hC3, 2'd1);
    read_reg(5'd12, v);
    check("dasel_t", v, 32'hC3);

    // Same-cycle write and read of r5 goes through the bypass
    DY = 32'd7;
    tick();
    FS = 4'h0; S_Addr = 5'd5; Y_Sel = 3'd2; D_Addr = 5'd5; DA_sel = 2'd0; D_En = 1'b1;
    tick();
    D_En = 1'b0; Y_Sel = 3'd0;
    tick();
    check("bypass_rs", ALU_OUT, 32'd7);
    alu("add_wrap", 4'h2, 5'd5, 32'hFFFF_FFF9, 32'h0, 4'b1001);

    // ALU corner cases
    write_reg(5'd1, 32'h7FFF_FFFF, 2'd0);
    write_reg(5'd2, 32'h8000_0000, 2'd0);
    write_reg(5'd3, 32'hFFFF_FFFF, 2'd0);
    write_reg(5'd4, 32'd4, 2'd0);
    write_reg(5'd6, 32'd1, 2'd0);
    alu("add_ovf", 4'h2, 5'd1, 32'd1, 32'h8000_0000, 4'b0110);
    alu("sra", 4'hE, 5'd4, 32'h8000_0000, 32'hF800_0000, 4'b0010);
    alu("srl", 4'hD, 5'd4, 32'h8000_0000, 32'h0800_0000, 4'b0000);
    alu("slt", 4'h6, 5'd3, 32'd1, 32'd1, 4'b0000);
    alu("sltu", 4'h7, 5'd3, 32'd1, 32'd0, 4'b0001);
    alu("sub_zero", 4'h4, 5'd6, 32'd1, 32'd0, 4'b1001);
    alu("sub_borrow", 4'h5, 5'd6, 32'd2, 32'hFFFF_FFFF, 4'b0010);
    alu("lui", 4'hF, 5'd0, 32'h0000_1234, 32'h1234_0000, 4'b0000);
    alu("nor", 4'hB, 5'd1, 32'h0000_00FF, 32'h8000_0000, 4'b0010);

    // Multiply/divide
    write_reg(5'd7, 32'hFFFF_FFFD, 2'd0);
    md_go(2'b01, 5'd7, 32'd5);
    md_wait("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0, 1'b1);
    tick();
    check("mult_done_pulse", 32'(MD_done), 0);

    write_reg(5'd8, 32'hFFFF_FFF9, 2'd0);
    md_go(2'b11, 5'd8, 32'd2);
    md_wait("div_m7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF1, 1'b0);
    write_reg(5'd9, 32'd7, 2'd0);
    md_go(2'b10, 5'd9, 32'd0);
    md_wait("divu_by0", 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    md_go(2'b11, 5'd2, 32'hFFFF_FFFF);
    md_wait("div_min_m1", 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    md_go(2'b00, 5'd3, 32'd2);
    md_wait("multu_big", 32'h1, 32'hFFFF_FFFE, 32'h8000_0000, 1'b0);

    // Reset in the middle of a divide
    md_go(2'b11, 5'd8, 32'd2);
    repeat (10) tick();
    #2 RESET = 1'b0;
    #1;
    check("midrst_busy", 32'(MD_busy), 0);
    Y_Sel = 3'd3;
    #1;
    check("midrst_lo", ALU_OUT, 0);
    Y_Sel = 3'd4;
    #1;
    check("midrst_hi", ALU_OUT, 0);
    Y_Sel = 3'd0;
    #1 RESET = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (MD_done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 0);
    $display("md midrst done_pulses=%0d", done_seen);

    // Back-to-back start from DONE
    write_reg(5'd5, 32'd7, 2'd0);
    md_go(2'b10, 5'd5, 32'd2);
    md_wait("divu_7by2", 32'd1, 32'd3, 32'h0, 1'b0);
    MD_op = 2'b00; MD_start = 1'b1;
    tick();
    MD_start = 1'b0;
    md_wait("b2b_multu", 32'd0, 32'd14, 32'd3, 1'b0);
    tick();
    check("b2b_done_pulse", 32'(MD_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
